// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: shared definitions for the 4x3 keypad scanner.
//   - key index codes KEY_0..KEY_9, KEY_STAR, KEY_HASH (4-bit, 0-11)
//   - FSM state encoding and frame count classes
//   - fixed snapshot-position -> key-index map (position = row*3 + col)
package keypad_scan_pkg;

    typedef logic [3:0] key_idx_t;

    localparam key_idx_t KEY_0    = 4'd0;
    localparam key_idx_t KEY_1    = 4'd1;
    localparam key_idx_t KEY_2    = 4'd2;
    localparam key_idx_t KEY_3    = 4'd3;
    localparam key_idx_t KEY_4    = 4'd4;
    localparam key_idx_t KEY_5    = 4'd5;
    localparam key_idx_t KEY_6    = 4'd6;
    localparam key_idx_t KEY_7    = 4'd7;
    localparam key_idx_t KEY_8    = 4'd8;
    localparam key_idx_t KEY_9    = 4'd9;
    localparam key_idx_t KEY_STAR = 4'd10;
    localparam key_idx_t KEY_HASH = 4'd11;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } key_cls_t;

    // Snapshot position (row*3 + col) to key index.
    function automatic key_idx_t pos_to_key(input logic [3:0] pos);
        case (pos)
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_4;
            4'd4:    return KEY_5;
            4'd5:    return KEY_6;
            4'd6:    return KEY_7;
            4'd7:    return KEY_8;
            4'd8:    return KEY_9;
            4'd9:    return KEY_STAR;
            4'd10:   return KEY_0;
            default: return KEY_HASH;
        endcase
    endfunction

endpackage

// File: rtl/keypad_onehot_dec.sv
// keypad_onehot_dec: classifies a 12-bit key snapshot.
//   snap : input  [11:0] one bit per key position (row*3 + col), 1 = pressed
//   cls  : output        NONE / SINGLE / MULTI
//   key  : output [3:0]  key index of the lowest pressed position (valid for SINGLE)
module keypad_onehot_dec
    import keypad_scan_pkg::*;
(
    input  logic [11:0] snap,
    output key_cls_t    cls,
    output key_idx_t    key
);

    logic [3:0] ones;
    logic [3:0] pos;
    logic       found;

    always_comb begin
        ones  = '0;
        pos   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                ones = ones + 4'd1;
                if (!found) begin
                    pos   = 4'(i);
                    found = 1'b1;
                end
            end
        end

        if (ones == 4'd0)
            cls = CLS_NONE;
        else if (ones == 4'd1)
            cls = CLS_SINGLE;
        else
            cls = CLS_MULTI;

        key = pos_to_key(pos);
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4-row x 3-column matrix keypad front end.
//   clk       : input       system clock (1 kHz)
//   rst       : input       asynchronous reset, active low
//   key_row   : input  [3:0] keypad rows, active low, asynchronous
//   key_col   : output [2:0] column drive, active low, one bit low at a time
//   key_input : output [9:0] one-hot digit strobe, one clock wide
//   btn_done  : output       '#' strobe, one clock wide
//   key_held  : output       high while a key is accepted and not yet released
// Each column is driven for COL_CYCLES clocks; its rows are sampled on the last
// of them. A full frame is classified and fed to a debounce FSM that needs
// DEB_FRAMES identical single-key frames to accept and DEB_FRAMES empty frames
// to release.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned COL_CYCLES = 4,
    parameter int unsigned DEB_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] key_input,
    output logic       btn_done,
    output logic       key_held
);

    localparam int unsigned SUB_W = $clog2(COL_CYCLES);
    localparam int unsigned CNT_W = $clog2(DEB_FRAMES + 1);

    logic [3:0]       row_s1, row_s2;
    logic [SUB_W-1:0] sub_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      snap;
    logic [11:0]      frame;
    logic             col_last;
    logic             frame_eval;

    key_cls_t         cls;
    key_idx_t         key;

    state_t           state, state_nx;
    key_idx_t         cand, cand_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             fire;

    assign col_last   = (sub_cnt == SUB_W'(COL_CYCLES - 1));
    assign frame_eval = col_last && (col_idx == 2'd2);

    // Two-flop row synchroniser; idle (all ones) out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= key_row;
            row_s2 <= row_s1;
        end
    end

    // Column scan counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_cnt <= '0;
            col_idx <= '0;
        end else if (col_last) begin
            sub_cnt <= '0;
            col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_COLS; c++)
            key_col[c] = (col_idx != 2'(c));
    end

    // Snapshot with the current column's rows merged in, so evaluation on
    // the last cycle of column 2 sees the complete frame without waiting a clock.
    always_comb begin
        frame = snap;
        if (col_last) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++)
                for (int unsigned c = 0; c < NUM_COLS; c++)
                    if (col_idx == 2'(c))
                        frame[r*NUM_COLS + c] = ~row_s2[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            snap <= '0;
        else if (col_last)
            snap <= frame;
    end

    keypad_onehot_dec u_dec (
        .snap (frame),
        .cls  (cls),
        .key  (key)
    );

    // Debounce FSM, advancing only on frame evaluation.
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        fire     = 1'b0;
        if (frame_eval) begin
            case (state)
                IDLE: begin
                    if (cls == CLS_SINGLE) begin
                        state_nx = DEBOUNCE;
                        cand_nx  = key;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (cls == CLS_SINGLE) begin
                        if (key == cand) begin
                            if (cnt_inc == CNT_W'(DEB_FRAMES)) begin
                                fire     = 1'b1;
                                state_nx = PRESSED;
                            end else begin
                                cnt_nx = cnt_inc;
                            end
                        end else begin
                            cand_nx = key;
                            cnt_nx  = CNT_W'(1);
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESSED: begin
                    if (cls == CLS_NONE) begin
                        state_nx = RELEASE;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cls == CLS_NONE) begin
                        if (cnt_inc == CNT_W'(DEB_FRAMES))
                            state_nx = IDLE;
                        else
                            cnt_nx = cnt_inc;
                    end else begin
                        state_nx = PRESSED;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cand      <= KEY_0;
            cnt       <= '0;
            key_input <= '0;
            btn_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            key_input <= (fire && (cand <= KEY_9)) ? (10'd1 << cand) : '0;
            btn_done  <= fire && (cand == KEY_HASH);
        end
    end

    assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed test of keypad_scan against a frame-level model.
// The bench emulates the physical keypad (rows follow the driven column and the
// set of keys held down) and predicts outputs from the scan/debounce rules.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] key_input;
    logic       btn_done;
    logic       key_held;

    // keys_down bit p = key at row p/3, column p%3 is physically pressed.
    logic [11:0] keys_down = '0;

    always #5 clk = ~clk;

    assign key_row[0] = ~|(keys_down[2:0]  & ~key_col);
    assign key_row[1] = ~|(keys_down[5:3]  & ~key_col);
    assign key_row[2] = ~|(keys_down[8:6]  & ~key_col);
    assign key_row[3] = ~|(keys_down[11:9] & ~key_col);

    keypad_scan #(.COL_CYCLES(4), .DEB_FRAMES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_input (key_input),
        .btn_done  (btn_done),
        .key_held  (key_held)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_strobe = 0;
    int last_cyc = 0;
    logic [9:0] last_ki = '0;
    logic       last_bd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    // Clock edges since reset; interval after edge e sits at scan position e%12.
    int          m_edge = 0;
    logic [11:0] h1 = '0, h2 = '0;   // keys_down one and two intervals back
    logic [11:0] fr = '0;            // frame assembled from column samples
    int          streak_key = 0, streak_len = 0, empty_len = 0;
    bit          held = 1'b0;
    logic [9:0]  exp_ki = '0;
    logic        exp_bd = 1'b0;
    logic [2:0]  exp_col = 3'b110;

    function automatic int key_of(input int pos);
        case (pos)
            0: return 1;  1: return 2;  2: return 3;
            3: return 4;  4: return 5;  5: return 6;
            6: return 7;  7: return 8;  8: return 9;
            9: return 10; 10: return 0; default: return 11;
        endcase
    endfunction

    task automatic m_reset();
        m_edge = 0; h1 = '0; h2 = '0; fr = '0;
        streak_key = 0; streak_len = 0; empty_len = 0; held = 1'b0;
        exp_ki = '0; exp_bd = 1'b0; exp_col = 3'b110;
    endtask

    task automatic m_eval();
        int n, k;
        n = $countones(fr);
        k = -1;
        for (int p = 0; p < 12; p++)
            if (fr[p] && k < 0) k = key_of(p);
        if (!held) begin
            if (n == 1) begin
                if (streak_len > 0 && k == streak_key) streak_len++;
                else begin streak_key = k; streak_len = 1; end
                if (streak_len == 3) begin
                    held = 1'b1; empty_len = 0; streak_len = 0;
                    if (k <= 9) exp_ki = 10'(1) << k;
                    else if (k == 11) exp_bd = 1'b1;
                end
            end else begin
                streak_len = 0;
            end
        end else begin
            if (n == 0) begin
                empty_len++;
                if (empty_len == 3) held = 1'b0;
            end else begin
                empty_len = 0;
            end
        end
    endtask

    task automatic m_step();
        int pre, col;
        m_edge++;
        exp_ki = '0;
        exp_bd = 1'b0;
        pre = (m_edge - 1) % 12;
        if (pre % 4 == 3) begin
            col = pre / 4;
            // column sample sees the keypad as it was two clocks earlier
            for (int p = 0; p < 12; p++)
                if (p % 3 == col) fr[p] = h2[p];
        end
        if (m_edge % 12 == 0) m_eval();
        h2 = h1;
        h1 = keys_down;
        exp_col = ~(3'b001 << ((m_edge % 12) / 4));
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    // ---------------- compare / strobe monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("key_col",   {29'd0, key_col},   {29'd0, exp_col});
            check("key_input", {22'd0, key_input}, {22'd0, exp_ki});
            check("btn_done",  {31'd0, btn_done},  {31'd0, exp_bd});
            check("key_held",  {31'd0, key_held},  {31'd0, held});
            if (key_input != '0 || btn_done) begin
                n_strobe++;
                last_ki  = key_input;
                last_bd  = btn_done;
                last_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Move to the interval right after a frame evaluation edge.
    task automatic align();
        for (int i = 0; i < 13 && (m_edge % 12) != 0; i++) tick(1);
        if ((m_edge % 12) != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL align: got %0d want 0 at cyc %0d", m_edge % 12, cyc);
        end
    endtask

    int base, press_cyc, stable_cyc, rel_cyc;

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_key_col",   {29'd0, key_col}, 32'h6);
        check("rst_key_input", {22'd0, key_input}, 32'h0);
        check("rst_btn_done",  {31'd0, btn_done}, 32'h0);
        check("rst_key_held",  {31'd0, key_held}, 32'h0);
        tick(3);
        rst = 1'b1;

        // idle scan
        base = n_strobe;
        tick(200);
        check("idle_strobes", n_strobe - base, 0);
        check("idle_held", {31'd0, key_held}, 0);
        align();
        check("col_phase0", {29'd0, key_col}, 32'h6);
        tick(4);
        check("col_phase1", {29'd0, key_col}, 32'h5);
        tick(4);
        check("col_phase2", {29'd0, key_col}, 32'h3);

        // '5' press and release
        align();
        base = n_strobe;
        press_cyc = cyc;
        keys_down = 12'(1) << 4;
        tick(100);
        check("k5_count", n_strobe - base, 1);
        check("k5_value", {22'd0, last_ki}, 32'h020);
        check("k5_latency", {31'd0, (last_cyc - press_cyc) <= 49}, 1);
        check("k5_held", {31'd0, key_held}, 1);
        keys_down = '0;
        tick(60);
        check("k5_no_repeat", n_strobe - base, 1);
        check("k5_released", {31'd0, key_held}, 0);

        // '#' then '*'
        align();
        base = n_strobe;
        keys_down = 12'(1) << 11;
        tick(60);
        check("hash_count", n_strobe - base, 1);
        check("hash_bd", {31'd0, last_bd}, 1);
        check("hash_ki", {22'd0, last_ki}, 0);
        keys_down = '0;
        tick(60);
        align();
        base = n_strobe;
        keys_down = 12'(1) << 9;
        tick(60);
        check("star_no_strobe", n_strobe - base, 0);
        check("star_held", {31'd0, key_held}, 1);
        keys_down = '0;
        tick(60);
        check("star_released", {31'd0, key_held}, 0);

        // bouncing '7'
        align();
        base = n_strobe;
        for (int i = 0; i < 8; i++) begin
            keys_down = (i % 2 == 0) ? (12'(1) << 6) : '0;
            tick(5);
        end
        keys_down = 12'(1) << 6;
        stable_cyc = cyc;
        tick(80);
        check("k7_count", n_strobe - base, 1);
        check("k7_value", {22'd0, last_ki}, 32'h080);
        check("k7_after_stable", {31'd0, (last_cyc - stable_cyc) >= 24}, 1);
        keys_down = '0;
        tick(60);

        // '1' + '2' together, then '1' alone
        align();
        base = n_strobe;
        keys_down = 12'b0000_0000_0011;
        tick(60);
        check("multi_none", n_strobe - base, 0);
        keys_down = 12'b0000_0000_0001;
        tick(60);
        check("k1_count", n_strobe - base, 1);
        check("k1_value", {22'd0, last_ki}, 32'h002);
        keys_down = '0;
        tick(60);

        // reset during debounce of '9'
        align();
        base = n_strobe;
        keys_down = 12'(1) << 8;
        tick(26);
        rst = 1'b0;
        #1;
        check("midrst_key_col",   {29'd0, key_col}, 32'h6);
        check("midrst_key_input", {22'd0, key_input}, 0);
        check("midrst_btn_done",  {31'd0, btn_done}, 0);
        check("midrst_key_held",  {31'd0, key_held}, 0);
        tick(3);
        rst = 1'b1;
        rel_cyc = cyc;
        tick(30);
        check("k9_early", n_strobe - base, 0);
        tick(20);
        check("k9_count", n_strobe - base, 1);
        check("k9_value", {22'd0, last_ki}, 32'h200);
        check("k9_latency", last_cyc - rel_cyc, 36);
        keys_down = '0;
        tick(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
